pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs, stage enables/flushes, perf counters.
// master = datapath side driving hazard info, slave = the hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        mem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_bubble;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble,
           stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble,
           stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: memory freeze > redirect flush > load-use bubble.
// Control outputs are combinational (0 latency); counters/timeout update on the next edge.
module pipe_hazard_ctrl (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load_use;
  logic        mem_busy;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        stall_inc;
  logic        flush_inc;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_inc;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        mem_timeout;

  assign rs1_hit  = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit  = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign mem_busy = bus.mem_req && !bus.dmem_ready;
  assign wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  // Both states share the same output rules; the state only tracks the wait window.
  always_comb begin
    state_nxt          = state;
    bus.pc_write       = 1'b1;
    bus.if_id_write    = 1'b1;
    bus.id_ex_write    = 1'b1;
    bus.ex_mem_write   = 1'b1;
    bus.if_id_flush    = 1'b0;
    bus.id_ex_flush    = 1'b0;
    bus.mem_wb_bubble  = 1'b0;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;
    case (state)
      RUN:      state_nxt = mem_busy ? MEM_WAIT : RUN;
      MEM_WAIT: state_nxt = mem_busy ? MEM_WAIT : RUN;
      default:  state_nxt = RUN;
    endcase
    if (!reset) begin
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_write   = 1'b0;
      bus.ex_mem_write  = 1'b0;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_flush   = 1'b1;
      bus.mem_wb_bubble = 1'b1;
    end else if (mem_busy) begin
      // Freeze everything; a pending redirect stays held in the frozen EX stage.
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_write   = 1'b0;
      bus.ex_mem_write  = 1'b0;
      bus.mem_wb_bubble = 1'b1;
      stall_inc         = 1'b1;
    end else if (bus.ex_redirect) begin
      bus.if_id_flush   = 1'b1;
      bus.id_ex_flush   = 1'b1;
      flush_inc         = 1'b1;
    end else if (load_use) begin
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_flush   = 1'b1;
      stall_inc         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      stall_cnt   <= 32'd0;
      flush_cnt   <= 32'd0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt + {31'd0, stall_inc};
      flush_cnt <= flush_cnt + {31'd0, flush_inc};
      if (state == MEM_WAIT) begin
        wait_cnt <= wait_inc;
        if (wait_inc == 8'hFF) begin
          mem_timeout <= 1'b1;
        end
      end else if (state_nxt == MEM_WAIT) begin
        wait_cnt <= 8'd0;
      end
    end
  end

  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;
  assign bus.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner sequences, random vs model.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       redir;
    logic       mreq;
    logic       rdy;
  } in_t;

  // ctl order: pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble
  typedef struct {
    string      name;
    in_t        in;
    logic [6:0] ctl;
  } vec_t;

  localparam logic [6:0] C_RST  = 7'b0000_111;
  localparam logic [6:0] C_BUSY = 7'b0000_001;
  localparam logic [6:0] C_FLSH = 7'b1111_110;
  localparam logic [6:0] C_LU   = 7'b0011_010;
  localparam logic [6:0] C_NORM = 7'b1111_000;

  int tests;
  int failed;

  // Reference model state: plain counts.
  longint m_stall;
  longint m_flush;
  int     m_waited;
  bit     m_in_wait;
  bit     m_timeout;
  in_t    cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_ctl();
    return {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write,
            hif.if_id_flush, hif.id_ex_flush, hif.mem_wb_bubble};
  endfunction

  function automatic bit is_lu(input in_t v);
    return v.mr && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
  endfunction

  function automatic logic [6:0] model_ctl(input in_t v, input logic rst);
    if (!rst) return C_RST;
    if (v.mreq && !v.rdy) return C_BUSY;
    if (v.redir) return C_FLSH;
    if (is_lu(v)) return C_LU;
    return C_NORM;
  endfunction

  task automatic drive(input in_t v, input logic rst);
    cur   = v;
    reset = rst;
    hif.id_rs1      = v.rs1;
    hif.id_rs2      = v.rs2;
    hif.id_uses_rs1 = v.u1;
    hif.id_uses_rs2 = v.u2;
    hif.ex_mem_read = v.mr;
    hif.ex_rd       = v.rd;
    hif.ex_redirect = v.redir;
    hif.mem_req     = v.mreq;
    hif.dmem_ready  = v.rdy;
    #4;
  endtask

  // Advance one edge, update the model, then compare the registered outputs.
  task automatic tick();
    bit busy;
    busy = cur.mreq && !cur.rdy;
    @(posedge clk);
    if (!reset) begin
      m_stall = 0; m_flush = 0; m_waited = 0; m_in_wait = 0; m_timeout = 0;
    end else begin
      if (busy) m_stall++;
      else if (cur.redir) m_flush++;
      else if (is_lu(cur)) m_stall++;
      if (m_in_wait) begin
        if (m_waited < 255) m_waited++;
        if (m_waited >= 255) m_timeout = 1;
      end else if (busy) begin
        m_waited = 0;
      end
      m_in_wait = busy;
    end
    #1;
    chk("stall_cnt", hif.stall_cnt, 32'(m_stall));
    chk("flush_cnt", hif.flush_cnt, 32'(m_flush));
    chk("mem_timeout", {31'd0, hif.mem_timeout}, {31'd0, m_timeout});
  endtask

  task automatic step(input in_t v, input logic rst, input string name);
    drive(v, rst);
    chk(name, {25'd0, dut_ctl()}, {25'd0, model_ctl(v, rst)});
    tick();
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic mr, input logic [4:0] rd,
                             input logic redir, input logic mreq, input logic rdy);
    in_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
    v.redir = redir; v.mreq = mreq; v.rdy = rdy;
    return v;
  endfunction

  vec_t vecs[$];
  in_t  idle;
  in_t  busy_v;
  in_t  rel_v;

  initial begin
    tests = 0;
    failed = 0;
    idle   = mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    busy_v = mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    rel_v  = mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    vecs.push_back('{"lu_rs1",       mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 1), C_LU});
    vecs.push_back('{"lu_rd0",       mk(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 1), C_NORM});
    vecs.push_back('{"lu_rs2",       mk(5'd3, 5'd9, 1, 1, 1, 5'd9, 0, 0, 1), C_LU});
    vecs.push_back('{"lu_unused",    mk(5'd7, 5'd7, 0, 0, 1, 5'd7, 0, 0, 1), C_NORM});
    vecs.push_back('{"no_load",      mk(5'd7, 5'd7, 1, 1, 0, 5'd7, 0, 0, 1), C_NORM});
    vecs.push_back('{"redir_lu",     mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 1), C_FLSH});
    vecs.push_back('{"redir",        mk(5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, 0), C_FLSH});
    vecs.push_back('{"busy_lu",      mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 0), C_BUSY});
    vecs.push_back('{"release_lu",   mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 1), C_LU});
    vecs.push_back('{"normal",       mk(5'd31, 5'd30, 1, 1, 1, 5'd29, 0, 0, 0), C_NORM});

    reset = 1'b0;
    drive(idle, 1'b0);
    @(posedge clk); #1;
    drive(idle, 1'b0);

    // Reset values
    chk("rst_ctl", {25'd0, dut_ctl()}, {25'd0, C_RST});
    tick();
    chk("rst_stall", hif.stall_cnt, 32'd0);
    chk("rst_timeout", {31'd0, hif.mem_timeout}, 32'd0);

    // Vector table: first vector is the single load-use stall (0 -> 1)
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in, 1'b1);
      chk(vecs[i].name, {25'd0, dut_ctl()}, {25'd0, vecs[i].ctl});
      tick();
      if (i == 0) chk("lu_stall_1", hif.stall_cnt, 32'd1);
    end

    // Redirect + load-use in the same cycle from reset
    step(idle, 1'b0, "rst2");
    drive(mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 1), 1'b1);
    chk("rl_pc_write", {31'd0, hif.pc_write}, 32'd1);
    tick();
    chk("rl_flush1", hif.flush_cnt, 32'd1);
    chk("rl_stall0", hif.stall_cnt, 32'd0);

    // 3-cycle memory wait, then release
    step(idle, 1'b0, "rst3");
    for (int i = 0; i < 3; i++) begin
      drive(busy_v, 1'b1);
      chk("mw_freeze", {25'd0, dut_ctl()}, {25'd0, C_BUSY});
      tick();
    end
    drive(rel_v, 1'b1);
    chk("mw_release", {25'd0, dut_ctl()}, {25'd0, C_NORM});
    tick();
    chk("mw_stall3", hif.stall_cnt, 32'd3);
    step(idle, 1'b1, "mw_run");

    // Redirect held through a 2-cycle wait
    step(idle, 1'b0, "rst4");
    for (int i = 0; i < 2; i++) begin
      drive(mk(5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, 0), 1'b1);
      chk("hold_noflush", {31'd0, hif.if_id_flush}, 32'd0);
      tick();
    end
    drive(mk(5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, 1), 1'b1);
    chk("hold_release", {25'd0, dut_ctl()}, {25'd0, C_FLSH});
    tick();
    step(idle, 1'b1, "hold_after");
    chk("hold_flush1", hif.flush_cnt, 32'd1);

    // Long wait: timeout after 255 MEM_WAIT cycles, sticky until reset
    step(idle, 1'b0, "rst5");
    step(busy_v, 1'b1, "to_entry");
    for (int k = 1; k <= 300; k++) begin
      step(busy_v, 1'b1, "to_wait");
      if (k == 254) chk("to_254", {31'd0, hif.mem_timeout}, 32'd0);
      if (k == 255) chk("to_255", {31'd0, hif.mem_timeout}, 32'd1);
    end
    step(rel_v, 1'b1, "to_release");
    for (int i = 0; i < 3; i++) step(idle, 1'b1, "to_after");
    chk("to_sticky", {31'd0, hif.mem_timeout}, 32'd1);
    step(idle, 1'b0, "to_reset");
    chk("to_cleared", {31'd0, hif.mem_timeout}, 32'd0);

    // Reset in the middle of a wait
    step(idle, 1'b1, "rst6_run");
    for (int i = 0; i < 3; i++) step(busy_v, 1'b1, "mid_wait");
    drive(busy_v, 1'b0);
    chk("mid_rst_ctl", {25'd0, dut_ctl()}, {25'd0, C_RST});
    tick();
    chk("mid_rst_stall", hif.stall_cnt, 32'd0);
    step(mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 1), 1'b1, "mid_rst_run");

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_t v;
      logic rst;
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom);
      v.u2    = 1'($urandom);
      v.mr    = 1'($urandom);
      v.rd    = 5'($urandom_range(0, 3));
      v.redir = ($urandom_range(0, 5) == 0);
      v.mreq  = ($urandom_range(0, 2) == 0);
      v.rdy   = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 99) != 0);
      step(v, rst, "rand_ctl");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
